// File: rtl/morse_keyer.sv
// Morse keyer: turns accepted ASCII characters into ITU-timed on/off keying.
// Optional audio tone output enabled by defining MORSE_TONE_EN.
module morse_keyer #(
  parameter int UNIT_W = 16
`ifdef MORSE_TONE_EN
  ,
  parameter int TONE_W = 12
`endif
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [UNIT_W-1:0] unit_cycles_i,
  input  logic [7:0]        ascii_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              morse_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
`ifdef MORSE_TONE_EN
  ,
  input  logic [TONE_W-1:0] tone_div_i,
  output logic              tone_o
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    GAP      = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  state_t            state_reg, state_next;
  logic [UNIT_W-1:0] unit_len_reg, unit_len_next;
  logic [UNIT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
  logic [1:0]        unit_cnt_reg, unit_cnt_next;
  logic [5:0]        code_reg, code_next;
  logic [2:0]        len_reg, len_next;
  logic [2:0]        idx_reg, idx_next;
  logic [9:0]        entry;
  logic [1:0]        units_m1;
  logic              last_cycle, state_end, timed;

  // Entry format {supported, length, elements}; first element in bit 5, 1 = dash.
  function automatic logic [9:0] lookup(input logic [7:0] ch);
    logic [7:0] uc;
    uc = (ch >= 8'h61 && ch <= 8'h7a) ? ch - 8'h20 : ch;
    lookup = '0;
    case (uc)
      "A": lookup = {1'b1, 3'd2, 6'b010000};
      "B": lookup = {1'b1, 3'd4, 6'b100000};
      "C": lookup = {1'b1, 3'd4, 6'b101000};
      "D": lookup = {1'b1, 3'd3, 6'b100000};
      "E": lookup = {1'b1, 3'd1, 6'b000000};
      "F": lookup = {1'b1, 3'd4, 6'b001000};
      "G": lookup = {1'b1, 3'd3, 6'b110000};
      "H": lookup = {1'b1, 3'd4, 6'b000000};
      "I": lookup = {1'b1, 3'd2, 6'b000000};
      "J": lookup = {1'b1, 3'd4, 6'b011100};
      "K": lookup = {1'b1, 3'd3, 6'b101000};
      "L": lookup = {1'b1, 3'd4, 6'b010000};
      "M": lookup = {1'b1, 3'd2, 6'b110000};
      "N": lookup = {1'b1, 3'd2, 6'b100000};
      "O": lookup = {1'b1, 3'd3, 6'b111000};
      "P": lookup = {1'b1, 3'd4, 6'b011000};
      "Q": lookup = {1'b1, 3'd4, 6'b110100};
      "R": lookup = {1'b1, 3'd3, 6'b010000};
      "S": lookup = {1'b1, 3'd3, 6'b000000};
      "T": lookup = {1'b1, 3'd1, 6'b100000};
      "U": lookup = {1'b1, 3'd3, 6'b001000};
      "V": lookup = {1'b1, 3'd4, 6'b000100};
      "W": lookup = {1'b1, 3'd3, 6'b011000};
      "X": lookup = {1'b1, 3'd4, 6'b100100};
      "Y": lookup = {1'b1, 3'd4, 6'b101100};
      "Z": lookup = {1'b1, 3'd4, 6'b110000};
      "0": lookup = {1'b1, 3'd5, 6'b111110};
      "1": lookup = {1'b1, 3'd5, 6'b011110};
      "2": lookup = {1'b1, 3'd5, 6'b001110};
      "3": lookup = {1'b1, 3'd5, 6'b000110};
      "4": lookup = {1'b1, 3'd5, 6'b000010};
      "5": lookup = {1'b1, 3'd5, 6'b000000};
      "6": lookup = {1'b1, 3'd5, 6'b100000};
      "7": lookup = {1'b1, 3'd5, 6'b110000};
      "8": lookup = {1'b1, 3'd5, 6'b111000};
      "9": lookup = {1'b1, 3'd5, 6'b111100};
      ".": lookup = {1'b1, 3'd6, 6'b010101};
      ",": lookup = {1'b1, 3'd6, 6'b110011};
      "?": lookup = {1'b1, 3'd6, 6'b001100};
      "/": lookup = {1'b1, 3'd5, 6'b100100};
      "=": lookup = {1'b1, 3'd5, 6'b100010};
      "-": lookup = {1'b1, 3'd6, 6'b100001};
      default: lookup = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg     <= IDLE;
      unit_len_reg  <= UNIT_W'(1);
      cycle_cnt_reg <= '0;
      unit_cnt_reg  <= '0;
      code_reg      <= '0;
      len_reg       <= '0;
      idx_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      unit_len_reg  <= unit_len_next;
      cycle_cnt_reg <= cycle_cnt_next;
      unit_cnt_reg  <= unit_cnt_next;
      code_reg      <= code_next;
      len_reg       <= len_next;
      idx_reg       <= idx_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    unit_len_next  = unit_len_reg;
    code_next      = code_reg;
    len_next       = len_reg;
    idx_next       = idx_reg;
    cycle_cnt_next = '0;
    unit_cnt_next  = '0;
    entry          = lookup(ascii_i);
    timed          = 1'b0;
    units_m1       = 2'd0;

    case (state_reg)
      MARK:     units_m1 = code_reg[5] ? 2'd2 : 2'd0;
      CHAR_GAP: units_m1 = 2'd2;
      WORD_GAP: units_m1 = 2'd3;
      default:  units_m1 = 2'd0;
    endcase
    last_cycle = (cycle_cnt_reg == unit_len_reg - UNIT_W'(1));
    state_end  = last_cycle && (unit_cnt_reg == units_m1);

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          unit_len_next = (unit_cycles_i == '0) ? UNIT_W'(1) : unit_cycles_i;
          code_next     = entry[5:0];
          len_next      = entry[8:6];
          idx_next      = '0;
          if (ascii_i == 8'h20)  state_next = WORD_GAP;
          else if (entry[9])     state_next = MARK;
          else                   state_next = ERR;
        end
      end
      MARK: begin
        timed = 1'b1;
        if (state_end) begin
          code_next  = {code_reg[4:0], 1'b0};
          idx_next   = idx_reg + 3'd1;
          state_next = (idx_reg + 3'd1 == len_reg) ? CHAR_GAP : GAP;
        end
      end
      GAP: begin
        timed = 1'b1;
        if (state_end) state_next = MARK;
      end
      CHAR_GAP, WORD_GAP: begin
        timed = 1'b1;
        if (state_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Counters restart whenever the state changes so each element is timed from zero.
    if (timed && state_next == state_reg) begin
      if (last_cycle) begin
        cycle_cnt_next = '0;
        unit_cnt_next  = unit_cnt_reg + 2'd1;
      end else begin
        cycle_cnt_next = cycle_cnt_reg + UNIT_W'(1);
        unit_cnt_next  = unit_cnt_reg;
      end
    end
  end

  assign ready_o = (state_reg == IDLE);
  assign busy_o  = (state_reg != IDLE);
  assign morse_o = (state_reg == MARK);
  assign done_o  = (state_reg == DONE);
  assign err_o   = (state_reg == ERR);

`ifdef MORSE_TONE_EN
  logic [TONE_W-1:0] tone_cnt_reg;
  logic              tone_reg;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (state_reg != MARK) begin
      tone_cnt_reg <= '0;
      tone_reg     <= 1'b0;
    end else if (tone_cnt_reg == tone_div_i) begin
      tone_cnt_reg <= '0;
      tone_reg     <= ~tone_reg;
    end else begin
      tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
    end
  end

  // Gated so the tone is silent the instant a mark ends.
  assign tone_o = tone_reg & morse_o;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Directed bench for morse_keyer: expected per-cycle outputs are queued when a
// character is driven and compared cycle by cycle as the keyer plays it out.
module tb_morse_keyer;
  localparam int UNIT_W = 16;

  logic              clk_i = 1'b0;
  logic              reset_ni = 1'b0;
  logic [UNIT_W-1:0] unit_cycles_i = '0;
  logic [7:0]        ascii_i = '0;
  logic              valid_i = 1'b0;
  logic              ready_o, morse_o, busy_o, done_o, err_o;
`ifdef MORSE_TONE_EN
  logic [11:0]       tone_div_i = 12'd1;
  logic              tone_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];  // {tone, morse, ready, busy, done, err}
  int drop_idx;

  morse_keyer #(.UNIT_W(UNIT_W)) dut (
    .clk_i(clk_i),
    .reset_ni(reset_ni),
    .unit_cycles_i(unit_cycles_i),
    .ascii_i(ascii_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .morse_o(morse_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
`ifdef MORSE_TONE_EN
    ,
    .tone_div_i(tone_div_i),
    .tone_o(tone_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic string ref_code(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";
      "E": return ".";
      "I": return "..";
      "K": return "-.-";
      "T": return "-";
      "Q": return "--.-";
      "0": return "-----";
      "7": return "--...";
      "?": return "..--..";
      ",": return "--..--";
      "/": return "-..-.";
      default: return "";
    endcase
  endfunction

  task automatic push(input logic t, input logic m, input logic r, input logic b,
                      input logic d, input logic e);
    exp_q.push_back({t, m, r, b, d, e});
  endtask

  // Tone model assumes tone_div_i = 1: square wave of period 4 starting low.
  task automatic push_char(input logic [7:0] c, input int u, input bit tail);
    string s;
    int n;
    s = ref_code(c);
    if (c == 8'h20) begin
      repeat (4 * u) push(0, 0, 0, 1, 0, 0);
      push(0, 0, 0, 1, 1, 0);
    end else if (s.len() == 0) begin
      push(0, 0, 0, 1, 0, 1);
    end else begin
      for (int i = 0; i < s.len(); i++) begin
        n = (s[i] == "-") ? 3 : 1;
        for (int j = 0; j < n * u; j++) push(((j / 2) % 2) == 1, 1, 0, 1, 0, 0);
        if (i < s.len() - 1) repeat (u) push(0, 0, 0, 1, 0, 0);
      end
      repeat (3 * u) push(0, 0, 0, 1, 0, 0);
      push(0, 0, 0, 1, 1, 0);
    end
    if (tail) push(0, 0, 1, 0, 0, 0);
  endtask

  task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed={morse,ready,busy,done,err}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drain(input string tag, input int drop_at);
    logic [5:0] e;
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk_i);
      e = exp_q.pop_front();
      check5($sformatf("%s[%0d]", tag, k), {morse_o, ready_o, busy_o, done_o, err_o}, e[4:0]);
`ifdef MORSE_TONE_EN
      checks++;
      assert (tone_o === e[5])
      else begin
        failures++;
        $error("FAIL %s_tone[%0d] observed=%b expected=%b", tag, k, tone_o, e[5]);
      end
`endif
      if (k == drop_at) begin
        @(posedge clk_i);
        #1 valid_i = 1'b0;
      end
      k++;
    end
  endtask

  task automatic start(input logic [7:0] c, input int u, input bit hold);
    @(posedge clk_i);
    #1;
    ascii_i = c;
    unit_cycles_i = UNIT_W'(u);
    valid_i = 1'b1;
    @(negedge clk_i);
    check5("ready_at_accept", {morse_o, ready_o, busy_o, done_o, err_o}, 5'b01000);
    @(posedge clk_i);
    #1;
    if (!hold) valid_i = 1'b0;
    $display("tx char=0x%02h U=%0d", c, u);
  endtask

  initial begin
    #12;
    check5("reset", {morse_o, ready_o, busy_o, done_o, err_o}, 5'b01000);
    @(negedge clk_i);
    reset_ni = 1'b1;

    start("E", 2, 0); push_char("E", 2, 1); drain("E_u2", -1);
    start("A", 1, 0); push_char("A", 1, 1); drain("A_u1", -1);
    start(8'h20, 3, 0); push_char(8'h20, 3, 1); drain("space_u3", -1);
    start("a", 1, 0); push_char("a", 1, 1); drain("a_u1", -1);

    start("#", 1, 0); push_char("#", 1, 1);
    repeat (3) push(0, 0, 1, 0, 0, 0);
    drain("unsupported", -1);

    start("E", 0, 0); push_char("E", 1, 1); drain("E_u0", -1);
    start("?", 1, 0); push_char("?", 1, 1); drain("qmark", -1);
    start("0", 2, 0); push_char("0", 2, 1); drain("zero", -1);
    start(",", 1, 0); push_char(",", 1, 1); drain("comma", -1);

    // valid held through E; T waits for the next idle cycle and U change applies to T only
    start("E", 2, 1);
    ascii_i = "T";
    unit_cycles_i = UNIT_W'(1);
    push_char("E", 2, 1);
    drop_idx = exp_q.size() - 1;
    push_char("T", 1, 1);
    drain("held_valid", drop_idx);

    start("T", 8, 0); push_char("T", 8, 1); drain("T_u8", -1);

    // reset during the fifth mark cycle of T at U=4
    start("T", 4, 0);
    repeat (4) begin
      @(negedge clk_i);
      check5("T_pre_reset", {morse_o, ready_o, busy_o, done_o, err_o}, 5'b10100);
    end
    @(posedge clk_i);
    #1;
    check5("T_mark5", {morse_o, ready_o, busy_o, done_o, err_o}, 5'b10100);
    reset_ni = 1'b0;
    #1;
    check5("async_reset", {morse_o, ready_o, busy_o, done_o, err_o}, 5'b01000);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    repeat (6) push(0, 0, 1, 0, 0, 0);
    drain("post_reset", -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
